// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared colour encoding, checker states and button decode
package simon_pkg;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      BLUE   = 2'd2,
      YELLOW = 2'd3
   } colour_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PRESS,
      WAIT_RELEASE,
      DONE_PASS,
      DONE_FAIL
   } check_state_t;

   // Returns {valid, colour}; anything other than exactly one button is invalid.
   function automatic logic [2:0] onehot_to_colour(input logic [3:0] btn);
      logic [2:0] r;
      case (btn)
         4'b0001: r = {1'b1, RED};
         4'b0010: r = {1'b1, GREEN};
         4'b0100: r = {1'b1, BLUE};
         4'b1000: r = {1'b1, YELLOW};
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop button synchronizer with rising-from-idle press detect
module btn_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_in,
   output logic [3:0] btn_s,
   output logic       press
);

   logic [3:0] sync1_q, sync1_d;
   logic [3:0] sync2_q, sync2_d;
   logic [3:0] prev_q, prev_d;

   always_comb begin
      sync1_d = btn_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 4'd0;
         sync2_q <= 4'd0;
         prev_q  <= 4'd0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign btn_s = sync2_q;
   // Only a transition out of all-released counts, so chords during a hold are not presses.
   assign press = (sync2_q != 4'd0) && (prev_q == 4'd0);

endmodule

// File: rtl/input_check.sv
// rtl/input_check.sv - checks player button presses against the stored colour sequence
module input_check
   import simon_pkg::*;
#(
   parameter int MAX_LEN = 33,
   parameter int TIMEOUT = 500
) (
   input  logic                   flash_clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [5:0]             round_len,
   input  logic [2*MAX_LEN-1:0]   segment,
   input  logic [3:0]             player_input,
   output logic                   busy,
   output logic                   press_valid,
   output logic [1:0]             press_colour,
   output logic [5:0]             idx,
   output logic                   pass,
   output logic                   fail
);

   localparam int              TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]   TMAX    = TW'(TIMEOUT - 1);
   localparam logic [5:0]      LEN_MAX = 6'(MAX_LEN);
   localparam int              SW      = $clog2(2 * MAX_LEN);

   logic [3:0] btn_s;
   logic       press;
   logic [2:0] enc;
   logic [SW-1:0] seg_base;
   logic [1:0] expected;

   check_state_t  state_q, state_d;
   logic [5:0]    len_q, len_d;
   logic [5:0]    idx_q, idx_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          busy_q, busy_d;
   logic          press_valid_q, press_valid_d;
   logic [1:0]    press_colour_q, press_colour_d;
   logic          press_ok_q, press_ok_d;
   logic          pass_q, pass_d;
   logic          fail_q, fail_d;

   btn_sync u_btn_sync (
      .clk    (flash_clk),
      .reset  (reset),
      .btn_in (player_input),
      .btn_s  (btn_s),
      .press  (press)
   );

   assign enc      = onehot_to_colour(btn_s);
   assign seg_base = SW'({idx_q, 1'b0});
   assign expected = segment[seg_base +: 2];

   // The press is registered first and judged a cycle later, so fail trails press_valid.
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      idx_d          = idx_q;
      timer_d        = timer_q;
      press_valid_d  = 1'b0;
      press_colour_d = press_colour_q;
      press_ok_d     = press_ok_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (round_len == 6'd0 || round_len > LEN_MAX) begin
                  state_d = DONE_FAIL;
               end else begin
                  len_d   = round_len;
                  idx_d   = 6'd0;
                  timer_d = '0;
                  state_d = WAIT_PRESS;
               end
            end
         end
         WAIT_PRESS: begin
            if (timer_q != TMAX) timer_d = timer_q + TW'(1);
            if (press) begin
               press_valid_d  = 1'b1;
               press_colour_d = enc[1:0];
               press_ok_d     = enc[2];
            end
            if (press_valid_q) begin
               if (press_ok_q && press_colour_q == expected) begin
                  idx_d   = idx_q + 6'd1;
                  timer_d = '0;
                  state_d = WAIT_RELEASE;
               end else begin
                  state_d = DONE_FAIL;
               end
            end else if (!press && timer_q == TMAX) begin
               state_d = DONE_FAIL;
            end
         end
         WAIT_RELEASE: begin
            timer_d = '0;
            if (btn_s == 4'd0) state_d = (idx_q == len_q) ? DONE_PASS : WAIT_PRESS;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == WAIT_PRESS) || (state_d == WAIT_RELEASE);
      pass_d = (state_d == DONE_PASS);
      fail_d = (state_d == DONE_FAIL);
   end

   always_ff @(posedge flash_clk) begin
      if (reset) begin
         state_q        <= IDLE;
         len_q          <= 6'd0;
         idx_q          <= 6'd0;
         timer_q        <= '0;
         busy_q         <= 1'b0;
         press_valid_q  <= 1'b0;
         press_colour_q <= 2'd0;
         press_ok_q     <= 1'b0;
         pass_q         <= 1'b0;
         fail_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         idx_q          <= idx_d;
         timer_q        <= timer_d;
         busy_q         <= busy_d;
         press_valid_q  <= press_valid_d;
         press_colour_q <= press_colour_d;
         press_ok_q     <= press_ok_d;
         pass_q         <= pass_d;
         fail_q         <= fail_d;
      end
   end

   assign busy         = busy_q;
   assign press_valid  = press_valid_q;
   assign press_colour = press_colour_q;
   assign idx          = idx_q;
   assign pass         = pass_q;
   assign fail         = fail_q;

endmodule

// File: tb/tb_input_check.sv
// tb/tb_input_check.sv - randomized scoreboard bench for input_check
module tb_input_check;

   localparam int MAX_LEN  = 33;
   localparam int TIMEOUT  = 20;
   localparam int EV_PRESS = 0;
   localparam int EV_PASS  = 1;
   localparam int EV_FAIL  = 2;

   logic                  flash_clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic [5:0]            round_len = 6'd0;
   logic [2*MAX_LEN-1:0]  segment = '0;
   logic [3:0]            player_input = 4'd0;
   logic                  busy, press_valid, pass, fail;
   logic [1:0]            press_colour;
   logic [5:0]            idx;

   input_check #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
      .flash_clk    (flash_clk),
      .reset        (reset),
      .start        (start),
      .round_len    (round_len),
      .segment      (segment),
      .player_input (player_input),
      .busy         (busy),
      .press_valid  (press_valid),
      .press_colour (press_colour),
      .idx          (idx),
      .pass         (pass),
      .fail         (fail)
   );

   always #5 flash_clk = ~flash_clk;

   int cyc = 0;
   always @(posedge flash_clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;
      int         at;
      bit         chk_col;
      logic [1:0] colour;
      logic [5:0] idx;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  checks = 0;
   int  errors = 0;

   int seg_m[MAX_LEN];
   bit act = 0;
   int t0 = 0, count = 0, len_m = 0, last_idx = 0, end_cyc = 0;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic push(input int kind, input int at, input bit chk_col, input int colour, input int ix);
      ev_t e;
      e.kind = kind; e.at = at; e.chk_col = chk_col;
      e.colour = 2'(colour); e.idx = 6'(ix);
      exp_q.push_back(e);
   endtask

   always @(negedge flash_clk) begin
      if (!reset && (press_valid || pass || fail)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", int'({press_valid, pass, fail}), 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_kind", int'({press_valid, pass, fail}), int'(3'b100 >> mon_e.kind));
            check("event_cycle", cyc, mon_e.at);
            check("event_idx", int'(idx), int'(mon_e.idx));
            check("event_busy", int'(busy), (mon_e.kind == EV_PRESS) ? 1 : 0);
            if (mon_e.chk_col) check("press_colour", int'(press_colour), int'(mon_e.colour));
         end
      end
   end

   task automatic tick();
      @(posedge flash_clk);
      #1;
   endtask

   task automatic load_seg(input bit randomize_it);
      for (int i = 0; i < MAX_LEN; i++) begin
         if (randomize_it) seg_m[i] = int'($urandom_range(0, 3));
         segment[2*i +: 2] = 2'(seg_m[i]);
      end
   endtask

   task automatic begin_round(input int len);
      int n;
      n = cyc;
      round_len = 6'(len);
      start = 1'b1;
      if (len < 1 || len > MAX_LEN) begin
         push(EV_FAIL, n + 1, 0, 0, last_idx);
         act = 0;
         end_cyc = n + 1;
         tick();
         start = 1'b0;
         check("bad_len_busy", int'(busy), 0);
      end else begin
         tick();
         start = 1'b0;
         check("start_busy", int'(busy), 1);
         act = 1; t0 = n + 1; count = 0; len_m = len; last_idx = 0;
      end
   endtask

   // Buttons rise after edge n; the press is seen on the third edge and judged on the fourth.
   task automatic do_press(input logic [3:0] btn, input int gap, input int hold, input bit extra, input bit spulse);
      int n, m, col;
      bit ok;
      if (!act) return;
      n = cyc + gap;
      if (n + 2 > t0 + TIMEOUT - 1) begin
         push(EV_FAIL, t0 + TIMEOUT, 0, 0, count);
         act = 0; end_cyc = t0 + TIMEOUT; last_idx = count;
         return;
      end
      while (cyc < n) tick();
      player_input = btn;
      start = spulse;
      col = 0;
      for (int b = 0; b < 4; b++) if (btn[b]) col = b;
      ok = ($countones(btn) == 1) && (col == seg_m[count]);
      push(EV_PRESS, n + 3, ($countones(btn) == 1), col, count);
      if (ok) begin
         count++;
      end else begin
         push(EV_FAIL, n + 4, 0, 0, count);
         act = 0; end_cyc = n + 4; last_idx = count;
      end
      tick();
      start = 1'b0;
      for (int k = 1; k < hold; k++) begin
         if (k == 1 && extra && ok) player_input = btn | (4'b0001 << ((col + 1) % 4));
         tick();
      end
      player_input = 4'd0;
      m = n + hold;
      if (ok) begin
         if (count == len_m) begin
            push(EV_PASS, m + 3, 0, 0, len_m);
            act = 0; end_cyc = m + 3; last_idx = len_m;
         end else begin
            t0 = m + 3;
         end
      end
   endtask

   task automatic finish_round();
      if (act) begin
         push(EV_FAIL, t0 + TIMEOUT, 0, 0, count);
         act = 0; end_cyc = t0 + TIMEOUT; last_idx = count;
      end
      while (cyc < end_cyc + 2) tick();
   endtask

   function automatic logic [3:0] good_btn();
      return 4'b0001 << seg_m[count];
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_press_valid"}, int'(press_valid), 0);
      check({tag, "_pass"}, int'(pass), 0);
      check({tag, "_fail"}, int'(fail), 0);
      check({tag, "_idx"}, int'(idx), 0);
      check({tag, "_press_colour"}, int'(press_colour), 0);
   endtask

   initial begin
      logic [3:0] b;
      int len, r;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      seg_m[0] = 2; seg_m[1] = 0; seg_m[2] = 3;
      load_seg(0);
      begin_round(3);
      do_press(4'b0100, 4, 4, 0, 0);
      do_press(4'b0001, 4, 4, 0, 0);
      do_press(4'b1000, 4, 4, 0, 0);
      finish_round();

      begin_round(3);
      do_press(4'b0100, 4, 4, 0, 0);
      do_press(4'b0010, 4, 4, 0, 0);
      finish_round();

      begin_round(3);
      do_press(4'b0101, 3, 4, 0, 0);
      finish_round();

      begin_round(0);  finish_round();
      begin_round(34); finish_round();
      begin_round(63); finish_round();

      begin_round(3);
      finish_round();

      load_seg(1);
      begin_round(2);
      do_press(good_btn(), 13, 3, 0, 0);
      do_press(good_btn(), 18, 3, 0, 0);
      finish_round();
      begin_round(2);
      do_press(good_btn(), 17, 2, 0, 0);
      do_press(good_btn(), 18, 2, 0, 0);
      finish_round();
      begin_round(1);
      do_press(good_btn(), 18, 3, 0, 0);
      finish_round();

      load_seg(1);
      begin_round(4);
      do_press(good_btn(), 2, 5, 1, 1);
      do_press(good_btn(), 3, 4, 1, 0);
      do_press(good_btn(), 1, 3, 0, 1);
      do_press(good_btn(), 2, 6, 1, 1);
      finish_round();

      load_seg(1);
      begin_round(3);
      do_press(good_btn(), 2, 4, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("midreset");
      check("midreset_queue", exp_q.size(), 0);
      act = 0; last_idx = 0;
      repeat (25) tick();
      begin_round(2);
      do_press(good_btn(), 3, 3, 0, 0);
      do_press(good_btn(), 3, 3, 0, 0);
      finish_round();

      load_seg(1);
      begin_round(MAX_LEN);
      for (int p = 0; p < MAX_LEN; p++) do_press(good_btn(), 1, 2, 0, 0);
      finish_round();

      for (int rnd = 0; rnd < 40; rnd++) begin
         load_seg(1);
         r = int'($urandom_range(0, 9));
         if (r == 0)      len = (int'($urandom_range(0, 1)) == 0) ? 0 : int'($urandom_range(34, 63));
         else             len = int'($urandom_range(1, 8));
         begin_round(len);
         for (int p = 0; p < 9 && act; p++) begin
            r = int'($urandom_range(0, 23));
            if (r == 0) begin
               b = 4'b0001 << ((seg_m[count] + int'($urandom_range(1, 3))) % 4);
            end else if (r == 1) begin
               b = 4'($urandom_range(0, 15));
               while ($countones(b) < 2) b = 4'($urandom_range(0, 15));
            end else begin
               b = good_btn();
            end
            do_press(b, (r == 2) ? int'($urandom_range(16, 22)) : int'($urandom_range(1, 6)),
                     int'($urandom_range(2, 6)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         finish_round();
      end

      repeat (5) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
